// File: rtl/conv_pkg.sv
// Shared constants, pixel/window types and tap indexing for the convolution window reader.
package conv_pkg;

  localparam int IMG_DIM = 28;
  localparam int KSZ     = 5;
  localparam int PAD     = (KSZ - 1) / 2;
  localparam int PAD_DIM = IMG_DIM + 2 * PAD;

  typedef logic [7:0] pix_t;
  typedef pix_t win_t [KSZ][KSZ];

  // Bit offset of tap (r,c) inside the flattened window bus.
  function automatic int tap_idx(input int r, input int c);
    return 8 * (KSZ * r + c);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One padded-row delay line: the output is the pixel pushed DEPTH shifts ago.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = PAD_DIM
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int PW = $clog2(DEPTH);

  pix_t           mem [DEPTH];
  logic [PW-1:0]  ptr_reg;

  // Contents are never reset; every entry is rewritten before it is read back.
  always_ff @(posedge clk) begin
    if (en) mem[ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr_reg <= '0;
    else if (en) ptr_reg <= (ptr_reg == PW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
  end

  assign dout = mem[ptr_reg];

endmodule

// File: rtl/conv_window_reader.sv
// Scans the zero-padded image out of SRAM and streams KSZ x KSZ windows with valid/ready.
// Optional build macro PAD_FORCE_ZERO_EN: skip padding reads and inject zeros instead.
module conv_window_reader
  import conv_pkg::*;
#(
  parameter int IMG_DIM = 28,
  parameter int KSZ     = 5,
  parameter int ADDR_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 sram_rd_en,
  output logic [ADDR_W-1:0]    sram_raddr,
  input  logic [7:0]           sram_rdata,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [8*KSZ*KSZ-1:0] win_data,
  output logic [4:0]           out_row,
  output logic [4:0]           out_col,
  output logic                 busy,
  output logic                 done
);

  localparam int PD   = (KSZ - 1) / 2;
  localparam int PDIM = IMG_DIM + 2 * PD;
  localparam int CW   = $clog2(PDIM);
  localparam int NLB  = KSZ - 1;

  logic              busy_reg, rd_vld_reg, rd_en_reg;
  logic [ADDR_W-1:0] raddr_reg;
  logic [CW-1:0]     rd_pr_reg, rd_pc_reg;
  logic              cap_pend_reg, cap_zero_reg;
  logic [CW-1:0]     cap_pr_reg, cap_pc_reg;
  logic              hold_vld_reg;
  pix_t              hold_data_reg;
  win_t              win_reg;
  logic              win_valid_reg, last_reg;
  logic [4:0]        out_row_reg, out_col_reg;

  logic              adv, issue, start_go, push, emit, last_pos, scan_last, nxt_zero;
  logic [CW-1:0]     nxt_pr, nxt_pc;
  pix_t              cap_pix, cur_pix;
  pix_t              col_pix [KSZ];
  pix_t              lb_in   [NLB];
  pix_t              lb_out  [NLB];

  always_comb begin
    adv       = ~win_valid_reg | win_ready;
    start_go  = start & ~busy_reg;
    issue     = adv & rd_vld_reg;
    cap_pix   = cap_zero_reg ? '0 : sram_rdata;
    // The hold register and a fresh SRAM return are never live together.
    cur_pix   = hold_vld_reg ? hold_data_reg : cap_pix;
    push      = (hold_vld_reg | cap_pend_reg) & adv;
    emit      = (cap_pr_reg >= CW'(KSZ - 1)) && (cap_pc_reg >= CW'(KSZ - 1));
    last_pos  = (cap_pr_reg == CW'(PDIM - 1)) && (cap_pc_reg == CW'(PDIM - 1));
    scan_last = (rd_pr_reg == CW'(PDIM - 1)) && (rd_pc_reg == CW'(PDIM - 1));
    nxt_pr    = rd_pr_reg;
    nxt_pc    = rd_pc_reg + 1'b1;
    if (start_go) begin
      nxt_pr = '0;
      nxt_pc = '0;
    end else if (rd_pc_reg == CW'(PDIM - 1)) begin
      nxt_pc = '0;
      nxt_pr = rd_pr_reg + 1'b1;
    end
`ifdef PAD_FORCE_ZERO_EN
    nxt_zero = (nxt_pr < CW'(PD)) || (nxt_pr >= CW'(PDIM - PD)) ||
               (nxt_pc < CW'(PD)) || (nxt_pc >= CW'(PDIM - PD));
`else
    nxt_zero = 1'b0;
`endif
  end

  // Read stage: registered strobe/address, held while the pipeline is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg   <= 1'b0;
      rd_vld_reg <= 1'b0;
      rd_en_reg  <= 1'b0;
      rd_pr_reg  <= '0;
      rd_pc_reg  <= '0;
      raddr_reg  <= '0;
    end else if (start_go) begin
      busy_reg   <= 1'b1;
      rd_vld_reg <= 1'b1;
      rd_en_reg  <= ~nxt_zero;
      rd_pr_reg  <= nxt_pr;
      rd_pc_reg  <= nxt_pc;
      raddr_reg  <= '0;
    end else begin
      if (done) busy_reg <= 1'b0;
      if (issue) begin
        if (scan_last) begin
          rd_vld_reg <= 1'b0;
          rd_en_reg  <= 1'b0;
        end else begin
          rd_en_reg <= ~nxt_zero;
          rd_pr_reg <= nxt_pr;
          rd_pc_reg <= nxt_pc;
          raddr_reg <= raddr_reg + 1'b1;
        end
      end
    end
  end

  // Capture, hold and window stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_pend_reg  <= 1'b0;
      cap_zero_reg  <= 1'b0;
      cap_pr_reg    <= '0;
      cap_pc_reg    <= '0;
      hold_vld_reg  <= 1'b0;
      hold_data_reg <= '0;
      win_valid_reg <= 1'b0;
      last_reg      <= 1'b0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
      for (int r = 0; r < KSZ; r++)
        for (int c = 0; c < KSZ; c++)
          win_reg[r][c] <= '0;
    end else begin
      cap_pend_reg <= issue;
      if (issue) begin
        cap_zero_reg <= ~rd_en_reg;
        cap_pr_reg   <= rd_pr_reg;
        cap_pc_reg   <= rd_pc_reg;
      end
      if (cap_pend_reg && !adv) begin
        hold_vld_reg  <= 1'b1;
        hold_data_reg <= cap_pix;
      end else if (adv) begin
        hold_vld_reg <= 1'b0;
      end
      if (adv) win_valid_reg <= push & emit;
      if (push) begin
        for (int r = 0; r < KSZ; r++) begin
          for (int c = 0; c < KSZ - 1; c++)
            win_reg[r][c] <= win_reg[r][c+1];
          win_reg[r][KSZ-1] <= col_pix[r];
        end
        if (emit) begin
          out_row_reg <= 5'(cap_pr_reg - CW'(KSZ - 1));
          out_col_reg <= 5'(cap_pc_reg - CW'(KSZ - 1));
          last_reg    <= last_pos;
        end
      end
    end
  end

  // Line buffer i delays by i+1 padded rows; the newest column enters at the bottom row.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NLB; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_in[gi] = cur_pix;
      end else begin : g_tail
        assign lb_in[gi] = lb_out[gi-1];
      end
      conv_line_buffer #(.DEPTH(PDIM)) u_lb (
        .clk  (clk),
        .rst  (rst),
        .en   (push),
        .din  (lb_in[gi]),
        .dout (lb_out[gi])
      );
      assign col_pix[gi] = lb_out[NLB-1-gi];
    end
    assign col_pix[KSZ-1] = cur_pix;

    for (gi = 0; gi < KSZ; gi++) begin : g_row
      for (gj = 0; gj < KSZ; gj++) begin : g_col
        assign win_data[tap_idx(gi, gj) +: 8] = win_reg[gi][gj];
      end
    end
  endgenerate

  assign sram_rd_en = rd_en_reg;
  assign sram_raddr = raddr_reg;
  assign win_valid  = win_valid_reg;
  assign out_row    = out_row_reg;
  assign out_col    = out_col_reg;
  assign done       = win_valid_reg & win_ready & last_reg;
  assign busy       = busy_reg & ~done;

endmodule

// File: tb/tb_conv_window_reader.sv
// Self-checking bench for conv_window_reader: SRAM model, window monitor, reference window model.
`timescale 1ns/1ps
module tb_conv_window_reader;
  import conv_pkg::*;

  localparam int NWIN = 784;
`ifdef PAD_FORCE_ZERO_EN
  localparam int NREADS = 784;
  localparam logic [7:0] JUNK_PAD = 8'hC3;
`else
  localparam int NREADS = 1024;
  localparam logic [7:0] JUNK_PAD = 8'h00;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sram_rd_en;
  logic [9:0]   sram_raddr;
  logic [7:0]   sram_rdata = 8'h00;
  logic         win_valid;
  logic         win_ready = 1'b1;
  logic [199:0] win_data;
  logic [4:0]   out_row, out_col;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_window_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sram_rd_en (sram_rd_en),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .done       (done)
  );

  logic [7:0] mem [1024];
  always @(posedge clk) if (sram_rd_en) sram_rdata <= mem[sram_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepted windows and frame events, sampled mid-cycle.
  logic         clr = 1'b1;
  int           win_cnt = 0, done_cnt = 0, done_cyc = 0, first_cyc = -1, rd_cnt = 0, stall_cnt = 0;
  logic [4:0]   acc_row  [NWIN];
  logic [4:0]   acc_col  [NWIN];
  logic [199:0] acc_data [NWIN];

  always @(negedge clk) begin
    if (clr) begin
      win_cnt = 0; done_cnt = 0; done_cyc = 0; first_cyc = -1; rd_cnt = 0; stall_cnt = 0;
    end else begin
      if (win_valid && first_cyc < 0) first_cyc = cyc;
      if (win_valid && win_ready) begin
        if (win_cnt < NWIN) begin
          acc_row[win_cnt]  = out_row;
          acc_col[win_cnt]  = out_col;
          acc_data[win_cnt] = win_data;
        end
        win_cnt++;
      end
      if (win_valid && !win_ready) stall_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (sram_rd_en && (!win_valid || win_ready)) rd_cnt++;
    end
  end

  // Reference model: what the convolution engine should see at padded (r,c).
  function automatic logic [7:0] eff_pix(input int r, input int c);
`ifdef PAD_FORCE_ZERO_EN
    if (r < 2 || r > 29 || c < 2 || c > 29) return 8'h00;
`endif
    return mem[r * 32 + c];
  endfunction

  function automatic logic [199:0] exp_win(input int row, input int col);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[tap_idx(r, c) +: 8] = eff_pix(row + r, col + c);
    return w;
  endfunction

  function automatic logic [7:0] tap_of(input logic [199:0] w, input int r, input int c);
    return w[tap_idx(r, c) +: 8];
  endfunction

  // Number of recorded windows that break the row-major sequence or carry wrong taps.
  function automatic int seq_errors();
    int errs;
    errs = 0;
    for (int i = 0; i < NWIN && i < win_cnt; i++) begin
      if (acc_row[i] !== 5'(i / 28) || acc_col[i] !== 5'(i % 28) ||
          acc_data[i] !== exp_win(i / 28, i % 28))
        errs++;
    end
    return errs;
  endfunction

  // kind 0: (28r+c) mod 256, kind 1: constant ival, kind 2: random.
  task automatic load_image(input int kind, input logic [7:0] ival, input logic [7:0] pval);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        if (r < 2 || r >= 30 || c < 2 || c >= 30) mem[r*32+c] = pval;
        else if (kind == 0) mem[r*32+c] = 8'((28 * (r - 2) + (c - 2)) % 256);
        else if (kind == 1) mem[r*32+c] = ival;
        else                mem[r*32+c] = 8'($urandom);
      end
  endtask

  task automatic begin_frame(output int t0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr   = 1'b0;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sram_rd_en, win_valid, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {sram_rd_en, win_valid, busy, done});
    end
    n_checks++;
    if (sram_raddr !== 10'd0 || {out_row, out_col} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_addr_pos: got addr=%0d row=%0d col=%0d expected 0", sram_raddr, out_row, out_col);
    end
    n_checks++;
    if (win_data !== '0) begin
      n_fail++;
      $display("FAIL reset_win_data: got %h expected 0", win_data);
    end
    rst = 1'b0;
    $display("reset: checked reset values");
  endtask

  task automatic test_basic_frame();
    int t0;
    bit to;
    logic [199:0] w0;
    load_image(0, 8'h00, 8'h00);
    win_ready = 1'b1;
    begin_frame(t0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_rise: got %b expected 1", busy);
    end
    wait_done(3000, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL basic_timeout: done not seen within bound");
    end
    n_checks++;
    if (first_cyc - t0 !== 135) begin
      n_fail++;
      $display("FAIL basic_first_valid: got cycle %0d expected 135", first_cyc - t0);
    end
    w0 = acc_data[0];
    n_checks++;
    if (tap_of(w0, 2, 2) !== 8'h00 || tap_of(w0, 4, 4) !== 8'h3A || tap_of(w0, 0, 0) !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_taps: got t22=%h t44=%h t00=%h expected 00 3a 00",
               tap_of(w0, 2, 2), tap_of(w0, 4, 4), tap_of(w0, 0, 0));
    end
    n_checks++;
    if (win_cnt !== NWIN || seq_errors() !== 0) begin
      n_fail++;
      $display("FAIL basic_sequence: got %0d windows, %0d bad expected 784, 0", win_cnt, seq_errors());
    end
    n_checks++;
    if (done_cyc - t0 !== 1026 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL basic_done: got cycle %0d count %0d expected 1026, 1", done_cyc - t0, done_cnt);
    end
    n_checks++;
    if (rd_cnt !== NREADS || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_reads_busy: got reads=%0d busy=%b expected %0d, 0", rd_cnt, busy, NREADS);
    end
    $display("basic_frame: windows=%0d done_at=%0d reads=%0d", win_cnt, done_cyc - t0, rd_cnt);
  endtask

  task automatic test_stall();
    int t0, c0;
    bit to, found, stable;
    logic [199:0] snap;
    load_image(0, 8'h00, 8'h00);
    win_ready = 1'b1;
    begin_frame(t0);
    found = 1'b0;
    c0 = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (win_valid && out_row == 5'd0 && out_col == 5'd5) begin
        found = 1'b1;
        c0 = cyc;
      end
    end
    win_ready = 1'b0;
    snap = win_data;
    stable = found;
    for (int i = 0; i < 10; i++) begin
      if (!(win_valid === 1'b1 && win_data === snap && out_col === 5'd5 && out_row === 5'd0)) stable = 1'b0;
      @(posedge clk); #1;
    end
    win_ready = 1'b1;
    n_checks++;
    if (!found || c0 - t0 !== 140) begin
      n_fail++;
      $display("FAIL stall_present: found=%b cycle %0d expected 140", found, c0 - t0);
    end
    n_checks++;
    if (!stable || snap !== exp_win(0, 5)) begin
      n_fail++;
      $display("FAIL stall_hold: stable=%b data=%h expected %h", stable, snap, exp_win(0, 5));
    end
    wait_done(3000, to);
    n_checks++;
    if (to || win_cnt !== NWIN || seq_errors() !== 0 || acc_col[6] !== 5'd6) begin
      n_fail++;
      $display("FAIL stall_sequence: timeout=%b windows=%0d bad=%0d col6=%0d expected 0,784,0,6",
               to, win_cnt, seq_errors(), acc_col[6]);
    end
    n_checks++;
    if (done_cyc - t0 !== 1036 || stall_cnt !== 10) begin
      n_fail++;
      $display("FAIL stall_done: got cycle %0d stalls %0d expected 1036, 10", done_cyc - t0, stall_cnt);
    end
    $display("stall: windows=%0d stalls=%0d done_at=%0d", win_cnt, stall_cnt, done_cyc - t0);
  endtask

  task automatic test_padding();
    int t0;
    bit to;
    logic [199:0] w0;
    load_image(1, 8'h10, 8'hFF);
    win_ready = 1'b1;
    begin_frame(t0);
    wait_done(3000, to);
    w0 = acc_data[0];
`ifdef PAD_FORCE_ZERO_EN
    n_checks++;
    if (tap_of(w0, 0, 0) !== 8'h00) begin
      n_fail++;
      $display("FAIL pad_tap00: got %h expected 00", tap_of(w0, 0, 0));
    end
`else
    n_checks++;
    if (tap_of(w0, 0, 0) !== 8'hFF) begin
      n_fail++;
      $display("FAIL pad_tap00: got %h expected ff", tap_of(w0, 0, 0));
    end
`endif
    n_checks++;
    if (to || tap_of(w0, 2, 2) !== 8'h10 || rd_cnt !== NREADS) begin
      n_fail++;
      $display("FAIL pad_reads: timeout=%b t22=%h reads=%0d expected 0, 10, %0d",
               to, tap_of(w0, 2, 2), rd_cnt, NREADS);
    end
    n_checks++;
    if (win_cnt !== NWIN || seq_errors() !== 0) begin
      n_fail++;
      $display("FAIL pad_sequence: got %0d windows, %0d bad expected 784, 0", win_cnt, seq_errors());
    end
    $display("padding: reads=%0d tap00=%h tap22=%h", rd_cnt, tap_of(w0, 0, 0), tap_of(w0, 2, 2));
  endtask

  task automatic test_restart_ignored();
    int t0, rd_before;
    bit to;
    load_image(2, 8'h00, JUNK_PAD);
    win_ready = 1'b1;
    begin_frame(t0);
    while (cyc < t0 + 500) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 1026) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, to);
    rd_before = rd_cnt;
    repeat (150) @(posedge clk);
    #1;
    n_checks++;
    if (to || done_cnt !== 1 || done_cyc - t0 !== 1026) begin
      n_fail++;
      $display("FAIL restart_done: timeout=%b count=%0d cycle=%0d expected 0, 1, 1026",
               to, done_cnt, done_cyc - t0);
    end
    n_checks++;
    if (win_cnt !== NWIN || seq_errors() !== 0) begin
      n_fail++;
      $display("FAIL restart_sequence: got %0d windows, %0d bad expected 784, 0", win_cnt, seq_errors());
    end
    n_checks++;
    if (busy !== 1'b0 || rd_cnt !== rd_before || rd_cnt !== NREADS) begin
      n_fail++;
      $display("FAIL restart_on_done: busy=%b reads=%0d expected 0, %0d", busy, rd_cnt, NREADS);
    end
    $display("restart_ignored: windows=%0d done_count=%0d", win_cnt, done_cnt);
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    bit to;
    load_image(0, 8'h00, 8'h00);
    win_ready = 1'b1;
    begin_frame(t0);
    while (cyc < t0 + 300) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({win_valid, busy, sram_rd_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid,busy,rd=%b expected 000", {win_valid, busy, sram_rd_en});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    begin_frame(t0);
    wait_done(3000, to);
    n_checks++;
    if (to || first_cyc - t0 !== 135) begin
      n_fail++;
      $display("FAIL midreset_first: timeout=%b first=%0d expected 0, 135", to, first_cyc - t0);
    end
    n_checks++;
    if (win_cnt !== NWIN || seq_errors() !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL midreset_sequence: windows=%0d bad=%0d done=%0d expected 784, 0, 1",
               win_cnt, seq_errors(), done_cnt);
    end
    $display("reset_mid_frame: windows=%0d first_at=%0d", win_cnt, first_cyc - t0);
  endtask

  task automatic test_saturated();
    int t0, nz, nff;
    bit to;
    logic [199:0] wl, wm;
    load_image(1, 8'hFF, JUNK_PAD);
    win_ready = 1'b1;
    begin_frame(t0);
    wait_done(3000, to);
    wl = acc_data[NWIN-1];
    wm = acc_data[13*28+13];
    nz = 0;
    nff = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (tap_of(wl, r, c) !== 8'h00) nz++;
        if (tap_of(wm, r, c) === 8'hFF) nff++;
      end
    n_checks++;
    if (to || nz !== 9 || tap_of(wl, 2, 2) !== 8'hFF || tap_of(wl, 3, 2) !== 8'h00) begin
      n_fail++;
      $display("FAIL sat_last_window: timeout=%b nonzero=%0d expected 0, 9", to, nz);
    end
    n_checks++;
    if (nff !== 25 || acc_row[13*28+13] !== 5'd13) begin
      n_fail++;
      $display("FAIL sat_mid_window: got %0d ff taps row %0d expected 25, 13", nff, acc_row[13*28+13]);
    end
    $display("saturated: last_nonzero=%0d mid_ff=%0d", nz, nff);
  endtask

  task automatic test_random_backpressure();
    int t0;
    bit to;
    load_image(2, 8'h00, JUNK_PAD);
    win_ready = 1'b1;
    begin_frame(t0);
    to = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
      win_ready = ($urandom_range(0, 3) != 0);
    end
    win_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (to || win_cnt !== NWIN || seq_errors() !== 0) begin
      n_fail++;
      $display("FAIL rand_sequence: timeout=%b windows=%0d bad=%0d expected 0, 784, 0",
               to, win_cnt, seq_errors());
    end
    n_checks++;
    if (done_cyc - t0 !== 1026 + stall_cnt || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL rand_done_timing: got cycle %0d count %0d expected %0d, 1",
               done_cyc - t0, done_cnt, 1026 + stall_cnt);
    end
    $display("random_backpressure: windows=%0d stalls=%0d done_at=%0d", win_cnt, stall_cnt, done_cyc - t0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_padding();
    test_restart_ignored();
    test_reset_mid_frame();
    test_saturated();
    test_random_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_reader.md
# conv_window_reader

Reads the zero-padded 32×32 compressed image out of SRAM, which the image compressor writes at addresses 66..957, and streams 5×5 pixel windows to the convolution engine. It produces one window per output position, 28×28 = 784 windows in row-major order, with a valid/ready handshake. The block sits between the compressed-image SRAM read port and the convolution datapath.

## Interface
Parameters:
- IMG_DIM, 28: compressed image side length.
- KSZ, 5: window side (odd); PAD = (KSZ-1)/2 = 2; PAD_DIM = IMG_DIM + 2·PAD = 32.
- ADDR_W, 10: SRAM address width; must satisfy 2^ADDR_W ≥ PAD_DIM².

Ports:
- clk  in  1  single clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy.
- sram_rd_en  out  1  SRAM read strobe.
- sram_raddr  out  ADDR_W  padded address, row·PAD_DIM + col.
- sram_rdata  in  8  read data, valid exactly 1 cycle after sram_rd_en.
- win_valid  out  1  win_data is valid.
- win_ready  in  1  consumer accepts the window.
- win_data  out  8·KSZ²  tap (r,c) at bits [8·(KSZ·r+c) +: 8]; r=0 is the top row, c=0 is the left column.
- out_row, out_col  out  5 each  output position of the current window, 0..27.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the last window (27,27) is accepted.

## Operation
Read side:
- The scan counters pr and pc step over 0..31 row-major, producing padded addresses 0..1023.
- The pipeline advances when adv = ~win_valid | win_ready.
- When adv=1, a read for the current (pr,pc) issues and the scan steps forward.
- When adv=0, the read strobe and address hold, and the scan does not step.

Capture and window build:
- Returned data lands in the capture stage.
- If the pipeline is frozen when data returns, the data goes to a one-entry hold register and is consumed first on resume. No data is lost or duplicated.
- Captured pixel p(pr,pc) is pushed into a 4-row line-buffer chain of PAD_DIM entries each.
- A 5×5 shift-register window is fed from the current pixel plus the four line-buffer outputs.

Window output:
- A window is emitted when pr ≥ 4 and pc ≥ 4.
- out_row = pr−4, out_col = pc−4; window tap (r,c) = padded pixel (pr−4+r, pc−4+c).
- win_data, out_row and out_col are registered and stay stable while win_valid && !win_ready.

End of frame and control events:
- After address 1023 is issued, reads stop. done pulses when window (27,27) is accepted, and busy falls in the same cycle.
- A start pulse while busy has no effect.
- A start pulse in the same cycle as done is ignored.
- rst clears the counters, valid flags, hold register, busy and done, and aborts any frame in progress. Line-buffer contents need no reset; stale data is overwritten before it is used.

Reset values:
- sram_rd_en=0, sram_raddr=0, win_valid=0, win_data=0, out_row=0, out_col=0, busy=0, done=0.

## Timing
These values assume no stalls, with start high in cycle 0:
- Read of address k issues in cycle 1+k.
- Data for address k is captured in cycle 2+k.
- The window containing pixel k is valid in cycle 3+k.
- The first window (0,0) has k=132 and is valid in cycle 135.
- The last window has k=1023 and is valid in cycle 1026; done pulses in cycle 1026 if win_ready=1.
- Each stall cycle (win_valid && !win_ready) delays all later events by exactly one cycle.

## Configuration
PAD_FORCE_ZERO_EN:
- Defined: for padded positions with row or column in {0,1,30,31}, sram_rd_en stays low and the value 0x00 is injected into the capture stage in place of sram_rdata. Padding is zero whatever the SRAM holds, and SRAM reads drop to 784 per frame.
- Undefined: all 1024 addresses are read and sram_rdata is used as returned. The SRAM must then hold zeros in the padding region.

## Structure
- Package conv_pkg holds:
  - Constants IMG_DIM, KSZ, PAD, PAD_DIM.
  - typedef logic [7:0] pix_t.
  - typedef pix_t win_t [KSZ][KSZ].
  - The function tap_idx(r,c).
- Sub-module conv_line_buffer is a PAD_DIM-deep, 8-bit delay line with a shift enable. The top level instantiates it KSZ−1 times.

## Test plan
1. Backdoor image pixel (r,c) = (28r+c) mod 256 into address 66+32r+c, zero the padding, hold win_ready=1, pulse start → window (0,0) valid in cycle 135 with tap(2,2)=0x00, tap(4,4)=0x3A and tap(0,0)=0x00; exactly 784 windows arrive in row-major order; done pulses in cycle 1026.
2. Using the image from scenario 1, drop win_ready for 10 cycles while window (0,5) is presented → win_data and out_col=5 are held stable; the next window is (0,6); 784 windows in total; done is delayed by 10 cycles.
3. Fill the padding with 0xFF and the interior with 0x10. With the macro defined, window (0,0) has tap(0,0)=0x00 and tap(2,2)=0x10, and 784 reads are issued. With the macro undefined, tap(0,0)=0xFF and 1024 reads are issued.
4. Pulse start again in cycle 500 of a frame → no restart, the window sequence continues, and done occurs once.
5. Assert rst in cycle 300 → win_valid, busy and sram_rd_en go low immediately. A new start after release gives a full frame with the first window (0,0) valid 135 cycles later.
6. All-0xFF interior with PAD_FORCE_ZERO_EN → window (27,27) has exactly 9 nonzero taps (r,c ≤ 2), and window (13,13) has all 25 taps equal to 0xFF.
